multiply_radix: RTL and testbench
=================================

# multiply_radix

Clocked, parametrised successor to the handshake shift-add multiplier. It computes x*y over a four-phase req/fin handshake and retires a configurable number of multiplier bits per cycle. It supports unsigned and two's-complement signed operands selected per operation, and can optionally terminate early when the remaining multiplier bits are zero. It is used wherever the math library needs a compact multi-cycle multiply with a synchronous interface.

## Interface
- Width, 32: bit width of x and y; result is 2*Width.
- Step, 1: multiplier bits retired per cycle; legal values 1, 2, 4; Width % Step == 0 (elaboration error otherwise).
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  1  four-phase request; operands sampled on the edge where req is seen high in IDLE.
- sgn  input  1  sampled with operands; 1 = signed two's-complement, 0 = unsigned.
- x  input  Width  multiplier.
- y  input  Width  multiplicand.
- fin  output  1  completion; high while result is valid and req remains high.
- result  output  2*Width  product; holds its value until the next operand capture.

## Operation
- States: IDLE, BUSY, SIGN, DONE.
- IDLE, req=1: capture operands.
  - mx = |x| and my = |y| when sgn=1; raw values otherwise. Magnitude of -2^(Width-1) is 2^(Width-1), which fits in Width unsigned bits.
  - neg = sgn & (x[Width-1] ^ y[Width-1]).
  - acc = 0, cnt = Width/Step, shift = 0, result cleared to 0. Go to BUSY.
- BUSY, each cycle:
  - acc += (mx[Step-1:0] * my) << shift.
  - mx >>= Step; shift += Step; cnt -= 1.
  - When cnt reaches 0, go to SIGN.
- SIGN: result <= neg ? -acc : acc (2*Width two's complement); fin <= 1; go to DONE.
- DONE: hold fin=1 and result while req=1. On req=0: fin <= 0, go to IDLE.
- A new operation starts only from IDLE. req held high through DONE never restarts a computation.
- x, y and sgn are ignored outside the capture edge.
- req falling during BUSY or SIGN is a protocol violation. The computation completes; fin is high for exactly one cycle in DONE, then the block returns to IDLE. result is retained.
- Arithmetic: acc is 2*Width bits; the partial product is Width+Step bits. No overflow is possible, including (-2^(Width-1))².

## Timing
- Reset (rst=1 at an edge): state IDLE, fin=0, result=0, acc=0, cnt=0. Takes effect from any state, aborting an in-flight operation. req high after reset deasserts starts a fresh capture.
- Capture edge is E0. Iterations occur on E1..EN, with N = Width/Step. SIGN occurs on EN+1, and fin is visible high after EN+1.
  - Latency: N+1 cycles from capture to fin.
  - Width=32, Step=1: 33 cycles. Width=32, Step=4: 9 cycles.
- fin falls on the first edge where req is sampled 0 in DONE. The earliest next capture is the following edge, so the minimum turnaround is N+3 cycles per operation.
- result changes only at the capture edge (cleared) and the SIGN edge.

## Configuration
- MULTIPLY_RADIX_EARLY_EXIT_EN defined: in BUSY, if the post-shift mx is 0, go to SIGN regardless of cnt.
  - Latency becomes ceil((msb index of |x| + 1)/Step)+1 cycles.
  - Minimum latency is 2 cycles, for x=0 or |x|=1 with Step=1.
  - The result is identical to the non-early-exit result.
- Undefined: fixed latency of N+1 cycles; the mx==0 check is not synthesised.

## Test plan
- Width=8, Step=1, sgn=0, x=255, y=255, req held: fin rises after E9, result=0xFE01; fin stays high while req=1. Drop req: fin low on the next edge, result still 0xFE01.
- Width=8, sgn=1: x=-128, y=-128 gives result=0x4000. x=-3, y=5 gives result=0xFFF1. x=0x80, y=0x80 with sgn=0 gives 0x4000. Also run 500 random operands of each mode against a reference model.
- Width=8, Step=2, sgn=0, x=200, y=3: fin after E5, result=600 (0x0258). Repeat with Step=4: fin after E3.
- With MULTIPLY_RADIX_EARLY_EXIT_EN, Width=8, Step=1: x=1, y=77 gives fin after E2, result=77. x=0, y=99 gives fin after E2, result=0. x=0x40, y=2 gives fin after E8, result=0x80. Without the macro, all three take 9 cycles.
- rst=1 at E4 of a Width=8, Step=1 operation: fin=0, result=0, state IDLE on the next edge. With req still high after rst deasserts, a new capture occurs and completes with correct latency.
- Protocol edges:
  - req held high for 40 cycles after fin: exactly one computation.
  - req pulsed for 1 cycle at E0: fin high only after E9, for one cycle; result valid and retained.
  - x changed during BUSY: result unaffected.

Source files
------------

// File: rtl/multiply_radix.sv
// multiply_radix: multi-cycle x*y over a four-phase req/fin handshake.
// Retires Step multiplier bits per cycle; sgn selects unsigned or
// two's-complement operands for each operation.
// Optional feature: define MULTIPLY_RADIX_EARLY_EXIT_EN to leave BUSY as soon
// as the remaining multiplier magnitude is zero.
module multiply_radix #(
  parameter int Width = 32,
  parameter int Step  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               sgn,
  input  logic [Width-1:0]   x,
  input  logic [Width-1:0]   y,
  output logic               fin,
  output logic [2*Width-1:0] result
);

  localparam int Iters = Width / Step;
  localparam int CntW  = $clog2(Iters + 1);
  localparam int ShW   = $clog2(Width + 1);
  localparam int AccW  = 2 * Width;
  localparam int PpW   = Width + Step;

  generate
    if (!(Step == 1 || Step == 2 || Step == 4) || (Width % Step) != 0) begin : gBadParams
      $error("multiply_radix: Step must be 1, 2 or 4 and must divide Width");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} stateT;

  stateT            stateQ, stateD;
  logic [Width-1:0] mxQ, mxD;
  logic [Width-1:0] myQ, myD;
  logic             negQ, negD;
  logic [AccW-1:0]  accQ, accD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [ShW-1:0]   shiftQ, shiftD;
  logic             finQ, finD;
  logic [AccW-1:0]  resultQ, resultD;

  logic [Width-1:0] absX, absY;
  logic [PpW-1:0]   partial;

  // Operand magnitudes; the magnitude of the most negative value wraps to
  // 2^(Width-1), which is exactly right when read as unsigned.
  always_comb begin
    absX = (sgn && x[Width-1]) ? -x : x;
    absY = (sgn && y[Width-1]) ? -y : y;
  end

  // Next-state and datapath: capture, shift-add iterations, sign fix, handshake.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    stateD  = stateQ;
    mxD     = mxQ;
    myD     = myQ;
    negD    = negQ;
    accD    = accQ;
    cntD    = cntQ;
    shiftD  = shiftQ;
    finD    = finQ;
    resultD = resultQ;
    partial = PpW'(mxQ[Step-1:0]) * PpW'(myQ);

    unique case (stateQ)
      IDLE: begin
        if (req) begin
          mxD     = absX;
          myD     = absY;
          negD    = sgn & (x[Width-1] ^ y[Width-1]);
          accD    = '0;
          cntD    = CntW'(Iters);
          shiftD  = '0;
          resultD = '0;
          stateD  = BUSY;
        end
      end
      BUSY: begin
        accD   = accQ + (AccW'(partial) << shiftQ);
        mxD    = mxQ >> Step;
        shiftD = shiftQ + ShW'(Step);
        cntD   = cntQ - 1'b1;
`ifdef MULTIPLY_RADIX_EARLY_EXIT_EN
        if (cntQ == CntW'(1) || mxD == '0) stateD = SIGN;
`else
        if (cntQ == CntW'(1)) stateD = SIGN;
`endif
      end
      SIGN: begin
        resultD = negQ ? -accQ : accQ;
        finD    = 1'b1;
        stateD  = DONE;
      end
      DONE: begin
        // A req that fell early is seen here, giving a single fin cycle.
        if (!req) begin
          finD   = 1'b0;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      stateQ  <= IDLE;
      mxQ     <= '0;
      myQ     <= '0;
      negQ    <= 1'b0;
      accQ    <= '0;
      cntQ    <= '0;
      shiftQ  <= '0;
      finQ    <= 1'b0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      mxQ     <= mxD;
      myQ     <= myD;
      negQ    <= negD;
      accQ    <= accD;
      cntQ    <= cntD;
      shiftQ  <= shiftD;
      finQ    <= finD;
      resultQ <= resultD;
    end
  end

  assign fin    = finQ;
  assign result = resultQ;

endmodule

// File: tb/tb_multiply_radix.sv
// Directed bench for multiply_radix at Width=8 with Step=1, 2 and 4.
// Expected latencies follow MULTIPLY_RADIX_EARLY_EXIT_EN when defined.
module tb_multiply_radix;

  logic        clk;
  logic        rst;
  logic        sgn;
  logic [7:0]  x, y;
  logic        reqV [3];
  logic        finV [3];
  logic [15:0] resV [3];

  int totalCnt = 0;
  int badCnt   = 0;

  multiply_radix #(.Width(8), .Step(1)) dut1 (
    .clk(clk), .rst(rst), .req(reqV[0]), .sgn(sgn), .x(x), .y(y),
    .fin(finV[0]), .result(resV[0]));
  multiply_radix #(.Width(8), .Step(2)) dut2 (
    .clk(clk), .rst(rst), .req(reqV[1]), .sgn(sgn), .x(x), .y(y),
    .fin(finV[1]), .result(resV[1]));
  multiply_radix #(.Width(8), .Step(4)) dut4 (
    .clk(clk), .rst(rst), .req(reqV[2]), .sgn(sgn), .x(x), .y(y),
    .fin(finV[2]), .result(resV[2]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Latency from capture edge to fin, counted in edges after E0.
  function automatic int expLat(input int k, input logic s, input logic [7:0] a);
`ifdef MULTIPLY_RADIX_EARLY_EXIT_EN
    int step;
    int bits;
    logic [7:0] m;
    step = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    m    = (s && a[7]) ? -a : a;
    bits = 1;
    for (int i = 0; i < 8; i++) if (m[i]) bits = i + 1;
    return (bits + step - 1) / step + 1;
`else
    int step;
    step = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    if (s) step = step + 0;
    if (a == 8'h00) step = step + 0;
    return 8 / step + 1;
`endif
  endfunction

  function automatic logic [15:0] refMul(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sp;
    if (s) begin
      sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
      return sp;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  // Called just before the capture edge; first posedge seen is E0.
  task automatic waitFin(input int k, output int lat);
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (finV[k]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input int k, input logic s,
                       input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    sgn = s; x = a; y = b; reqV[k] = 1'b1;
    waitFin(k, lat);
    check({tag, "_lat"}, lat, expLat(k, s, a));
    check({tag, "_res"}, resV[k], exp);
    @(negedge clk);
    reqV[k] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_finlow"}, finV[k], 1'b0);
    check({tag, "_kept"}, resV[k], exp);
  endtask

  initial begin
    int lat, drops, changes, firstFin, finCycles;
    logic [7:0] ra, rb;
    clk = 1'b0; rst = 1'b1; sgn = 1'b0; x = '0; y = '0;
    for (int i = 0; i < 3; i++) reqV[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_fin", finV[i], 1'b0);
      check("reset_res", resV[i], 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;

    // 255*255 with req held 40 cycles after fin: a single computation.
    @(negedge clk);
    sgn = 1'b0; x = 8'd255; y = 8'd255; reqV[0] = 1'b1;
    waitFin(0, lat);
    check("ff_lat", lat, expLat(0, 1'b0, 8'd255));
    check("ff_res", resV[0], 16'hFE01);
    drops = 0; changes = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!finV[0]) drops++;
      if (resV[0] !== 16'hFE01) changes++;
    end
    check("hold_fin_drops", drops, 0);
    check("hold_res_changes", changes, 0);
    @(negedge clk);
    reqV[0] = 1'b0;
    @(posedge clk); #1;
    check("ff_finlow", finV[0], 1'b0);
    check("ff_kept", resV[0], 16'hFE01);

    // Signed and unsigned corner operands.
    runOp("s_m128sq", 0, 1'b1, 8'h80, 8'h80, 16'h4000);
    runOp("s_m3x5",   0, 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    runOp("u_80sq",   0, 1'b0, 8'h80, 8'h80, 16'h4000);
    runOp("s_m1x1",   0, 1'b1, 8'hFF, 8'h01, 16'hFFFF);

    // Higher radix.
    runOp("r2_200x3", 1, 1'b0, 8'd200, 8'd3, 16'h0258);
    runOp("r4_200x3", 2, 1'b0, 8'd200, 8'd3, 16'h0258);
    runOp("r2_m128sq", 1, 1'b1, 8'h80, 8'h80, 16'h4000);
    runOp("r4_m3x5",  2, 1'b1, 8'hFD, 8'h05, 16'hFFF1);

    // Early-exit candidates (9 cycles each when the feature is off).
    runOp("ee_1x77",  0, 1'b0, 8'd1, 8'd77, 16'd77);
    runOp("ee_0x99",  0, 1'b0, 8'd0, 8'd99, 16'd0);
    runOp("ee_40x2",  0, 1'b0, 8'h40, 8'd2, 16'h0080);
    runOp("ee_r2_1x5", 1, 1'b0, 8'd1, 8'd5, 16'd5);

    // Reset while holding a result in DONE.
    @(negedge clk);
    sgn = 1'b0; x = 8'd255; y = 8'd2; reqV[0] = 1'b1;
    waitFin(0, lat);
    check("pre_rst_res", resV[0], 16'h01FE);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_done_fin", finV[0], 1'b0);
    check("rst_done_res", resV[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0; reqV[0] = 1'b0;
    @(posedge clk);

    // Reset sampled at E4 of an operation; req stays high afterwards.
    @(negedge clk);
    sgn = 1'b0; x = 8'd9; y = 8'd7; reqV[0] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_fin", finV[0], 1'b0);
    check("rst_busy_res", resV[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    waitFin(0, lat);
    check("post_rst_lat", lat, expLat(0, 1'b0, 8'd9));
    check("post_rst_res", resV[0], 16'd63);
    @(negedge clk);
    reqV[0] = 1'b0;
    @(posedge clk); #1;
    check("post_rst_finlow", finV[0], 1'b0);

    // req pulsed for a single cycle at E0.
    @(negedge clk);
    sgn = 1'b0; x = 8'd12; y = 8'd11; reqV[0] = 1'b1;
    @(negedge clk);
    reqV[0] = 1'b0;
    firstFin = -1; finCycles = 0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
      if (finV[0]) begin
        finCycles++;
        if (firstFin < 0) firstFin = c;
      end
    end
    check("pulse_first_fin", firstFin, expLat(0, 1'b0, 8'd12));
    check("pulse_fin_cycles", finCycles, 1);
    check("pulse_res", resV[0], 16'd132);

    // Operands changed during BUSY must not matter.
    @(negedge clk);
    sgn = 1'b0; x = 8'd13; y = 8'd17; reqV[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sgn = 1'b1; x = 8'hA5; y = 8'h5A;
    lat = -1;
    for (int c = 2; c < 40; c++) begin
      @(posedge clk); #1;
      if (finV[0]) begin
        lat = c;
        break;
      end
    end
    check("xchg_lat", lat, expLat(0, 1'b0, 8'd13));
    check("xchg_res", resV[0], 16'd221);
    @(negedge clk);
    reqV[0] = 1'b0;
    @(posedge clk);

    // Random operands against the reference product, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 500; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        runOp(m == 0 ? "rand_u" : "rand_s", i % 3, m[0], ra, rb, refMul(m[0], ra, rb));
      end
    end

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
